// File: rtl/lfsr_offset_finder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_offset_finder_pkg
// Description : Shared widths, default LH2 polynomials, FSM state encoding
//               and the LFSR step function for the LFSR offset finder.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_offset_finder_pkg;

    localparam int LFSR_W = 17;
    localparam int TS_W   = 24;

    // Default LH2 polynomials, listed most-significant lane first
    localparam logic [LFSR_W-1:0] LH2_POLY_A = 17'h13F67;
    localparam logic [LFSR_W-1:0] LH2_POLY_B = 17'h1FF6B;
    localparam logic [LFSR_W-1:0] LH2_POLY_C = 17'h17E04;
    localparam logic [LFSR_W-1:0] LH2_POLY_D = 17'h1D258;

    // Lane i occupies bits [17i+16:17i]; lane 0 is therefore LH2_POLY_D
    localparam logic [4*LFSR_W-1:0] LH2_POLY_LIST =
        {LH2_POLY_A, LH2_POLY_B, LH2_POLY_C, LH2_POLY_D};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One Fibonacci shift: feedback is the parity of the tapped bits
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s,
        input logic [LFSR_W-1:0] poly
    );
        return {s[LFSR_W-2:0], ^(s & poly)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_offset_finder_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_offset_finder_if
// Description : Valid/ready result bus from the offset finder to readout.
//               LFSR_OFFSET_FINDER_OVERRUN_EN adds the result_overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_offset_finder_if
    import lfsr_offset_finder_pkg::*;
#(
    parameter int PIDX_W = 2
) ();
    logic              result_valid;
    logic              result_ready;
    logic [PIDX_W-1:0] result_poly;
    logic [LFSR_W-1:0] result_offset;
    logic              result_no_match;
    logic [TS_W-1:0]   result_ts;
`ifdef LFSR_OFFSET_FINDER_OVERRUN_EN
    logic              result_overrun;
`endif

    modport master (
        output result_valid, result_poly, result_offset, result_no_match, result_ts,
`ifdef LFSR_OFFSET_FINDER_OVERRUN_EN
        output result_overrun,
`endif
        input  result_ready
    );

    modport slave (
        input  result_valid, result_poly, result_offset, result_no_match, result_ts,
`ifdef LFSR_OFFSET_FINDER_OVERRUN_EN
        input  result_overrun,
`endif
        output result_ready
    );
endinterface
`default_nettype wire

// File: rtl/lfsr17_lane.sv
`default_nettype none
// ============================================================================
// Module      : lfsr17_lane
// Description : One candidate 17-bit LFSR with load/step/hold and a
//               combinational compare against the terminal word.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr17_lane
    import lfsr_offset_finder_pkg::*;
#(
    parameter logic [LFSR_W-1:0] POLY       = LH2_POLY_D,
    parameter logic [LFSR_W-1:0] MATCH_WORD = 17'h00001
) (
    input  wire logic              clk_96MHz,
    input  wire logic              reset,
    input  wire logic              load,
    input  wire logic              step,
    input  wire logic [LFSR_W-1:0] load_value,
    output logic                   match
);
    logic [LFSR_W-1:0] r_state;

    // Load has priority over step; otherwise the lane holds
    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            r_state <= '0;
        end else if (load) begin
            r_state <= load_value;
        end else if (step) begin
            r_state <= lfsr_next(r_state, POLY);
        end
    end

    assign match = (r_state == MATCH_WORD);

endmodule
`default_nettype wire

// File: rtl/lfsr_offset_finder.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_offset_finder
// Description : Captures a decoded LH2 word, acks the decoder, steps N_POLY
//               LFSR lanes until one reaches MATCH_WORD and reports lane,
//               offset and timestamp on a valid/ready bus.
//               Optional macro: LFSR_OFFSET_FINDER_OVERRUN_EN (result_overrun).
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_offset_finder
    import lfsr_offset_finder_pkg::*;
#(
    parameter int                       N_POLY     = 4,
    parameter logic [N_POLY*LFSR_W-1:0] POLY_LIST  = LH2_POLY_LIST,
    parameter logic [LFSR_W-1:0]        MATCH_WORD = 17'h00001,
    parameter int                       MAX_STEPS  = 131071
) (
    input  wire logic              clk_96MHz,
    input  wire logic              reset,
    input  wire logic              enabled,
    input  wire logic [LFSR_W-1:0] decoded_data,
    input  wire logic              data_availible,
    input  wire logic [TS_W-1:0]   ts_last_data,
    output logic                   decoder_ack,
    output logic                   busy,
    lfsr_offset_finder_if.master   result
);
    localparam int PIDX_W = (N_POLY > 1) ? $clog2(N_POLY) : 1;
    localparam logic [LFSR_W-1:0] C_LAST_COUNT = LFSR_W'(MAX_STEPS - 1);
    localparam logic [LFSR_W-1:0] C_MAX_OFFSET = LFSR_W'(MAX_STEPS);

    state_t             r_state, w_next_state;
    logic [LFSR_W-1:0]  r_word;
    logic [TS_W-1:0]    r_ts;
    logic [LFSR_W-1:0]  r_count;
    logic               r_valid;
    logic               r_no_match;
    logic [PIDX_W-1:0]  r_poly;
    logic [LFSR_W-1:0]  r_offset;

    logic [N_POLY-1:0]  w_match;
    logic               w_any_match;
    logic [PIDX_W-1:0]  w_first;
    logic               w_capture, w_load, w_step, w_ack, w_accept;

    for (genvar gi = 0; gi < N_POLY; gi++) begin : g_lane
        lfsr17_lane #(
            .POLY       (POLY_LIST[gi*LFSR_W +: LFSR_W]),
            .MATCH_WORD (MATCH_WORD)
        ) u_lane (
            .clk_96MHz  (clk_96MHz),
            .reset      (reset),
            .load       (w_load),
            .step       (w_step),
            .load_value (r_word),
            .match      (w_match[gi])
        );
    end

    // Lowest-index matching lane wins when several match on the same step
    always_comb begin
        w_first = '0;
        for (int i = N_POLY - 1; i >= 0; i--) begin
            if (w_match[i]) w_first = PIDX_W'(i);
        end
        w_any_match = |w_match;
    end

    // Next-state and lane control; everything is frozen while disabled
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_ack        = 1'b0;
        w_accept     = 1'b0;
        if (enabled) begin
            case (r_state)
                IDLE: begin
                    if (data_availible) begin
                        w_capture    = 1'b1;
                        w_next_state = ACK;
                    end
                end
                ACK: begin
                    w_ack = 1'b1;
                    if (r_word == '0) begin
                        w_next_state = DONE;
                    end else begin
                        w_load       = 1'b1;
                        w_next_state = SEARCH;
                    end
                end
                SEARCH: begin
                    if (w_any_match || (r_count == C_LAST_COUNT)) begin
                        w_next_state = DONE;
                    end else begin
                        w_step = 1'b1;
                    end
                end
                DONE: begin
                    if (r_valid && result.result_ready) begin
                        w_accept     = 1'b1;
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture, step counter and result registers
    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            r_word     <= '0;
            r_ts       <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_no_match <= 1'b0;
            r_poly     <= '0;
            r_offset   <= '0;
        end else if (enabled) begin
            if (w_capture) begin
                r_word <= decoded_data;
                r_ts   <= ts_last_data;
            end
            case (r_state)
                ACK: begin
                    r_count <= '0;
                    if (r_word == '0) begin
                        r_valid    <= 1'b1;
                        r_no_match <= 1'b1;
                        r_poly     <= '0;
                        r_offset   <= '0;
                    end
                end
                SEARCH: begin
                    if (w_any_match) begin
                        r_valid    <= 1'b1;
                        r_no_match <= 1'b0;
                        r_poly     <= w_first;
                        r_offset   <= r_count;
                    end else if (r_count == C_LAST_COUNT) begin
                        r_valid    <= 1'b1;
                        r_no_match <= 1'b1;
                        r_poly     <= '0;
                        r_offset   <= C_MAX_OFFSET;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                DONE: begin
                    if (w_accept) begin
                        r_valid    <= 1'b0;
                        r_no_match <= 1'b0;
                        r_poly     <= '0;
                        r_offset   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LFSR_OFFSET_FINDER_OVERRUN_EN
    logic r_overrun;

    // Flags a fresh decoder word arriving while this one is still in flight
    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (enabled) begin
            if (w_accept) begin
                r_overrun <= 1'b0;
            end else if ((r_state != IDLE) && data_availible && (ts_last_data != r_ts)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign result.result_overrun = r_overrun;
`endif

    assign decoder_ack            = w_ack;
    assign busy                   = (r_state != IDLE);
    assign result.result_valid    = r_valid;
    assign result.result_poly     = r_poly;
    assign result.result_offset   = r_offset;
    assign result.result_no_match = r_no_match;
    assign result.result_ts       = r_ts;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_offset_finder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_offset_finder
// Description : Self-checking bench for lfsr_offset_finder (MAX_STEPS=16).
//               Honours LFSR_OFFSET_FINDER_OVERRUN_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_offset_finder;
    import lfsr_offset_finder_pkg::*;

    localparam int            TB_MAX   = 16;
    localparam logic [16:0]   TB_MATCH = 17'h00001;
    localparam logic [67:0]   TB_POLYS = {17'h13F67, 17'h1FF6B, 17'h17E04, 17'h1D258};

    typedef struct {
        logic [16:0] word;
        logic [23:0] ts;
        logic        exp_nm;
        logic [1:0]  exp_poly;
        logic [16:0] exp_off;
        int          exp_lat;
    } vec_t;

    logic        clk_96MHz = 1'b0;
    logic        reset = 1'b1;
    logic        enabled = 1'b1;
    logic [16:0] decoded_data = '0;
    logic        data_availible = 1'b0;
    logic [23:0] ts_last_data = '0;
    logic        decoder_ack;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    lfsr_offset_finder_if #(.PIDX_W(2)) res_if ();

    lfsr_offset_finder #(
        .N_POLY     (4),
        .POLY_LIST  (TB_POLYS),
        .MATCH_WORD (TB_MATCH),
        .MAX_STEPS  (TB_MAX)
    ) dut (
        .clk_96MHz      (clk_96MHz),
        .reset          (reset),
        .enabled        (enabled),
        .decoded_data   (decoded_data),
        .data_availible (data_availible),
        .ts_last_data   (ts_last_data),
        .decoder_ack    (decoder_ack),
        .busy           (busy),
        .result         (res_if)
    );

    always #5 clk_96MHz = ~clk_96MHz;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] poly_of(input int lane);
        logic [67:0] l;
        l = TB_POLYS;
        return l[lane*17 +: 17];
    endfunction

    function automatic logic [16:0] fwd(input logic [16:0] s, input logic [16:0] p);
        return {s[15:0], ^(s & p)};
    endfunction

    // Unique predecessor of s; valid because every tap set includes bit 16
    function automatic logic [16:0] back(input logic [16:0] s, input logic [16:0] p);
        logic [16:0] q;
        q = {1'b0, s[16:1]};
        if ((^(q & p)) != s[0]) q[16] = 1'b1;
        return q;
    endfunction

    // Reference: first hitting step per lane, earliest wins, ties to lower lane
    function automatic vec_t model(input logic [16:0] w, input logic [23:0] ts);
        vec_t        v;
        int          best_k;
        int          best_lane;
        logic [16:0] s;
        v.word = w;
        v.ts   = ts;
        if (w == '0) begin
            v.exp_nm = 1'b1; v.exp_poly = 2'd0; v.exp_off = '0; v.exp_lat = 2;
            return v;
        end
        best_k    = TB_MAX;
        best_lane = 0;
        for (int lane = 0; lane < 4; lane++) begin
            s = w;
            for (int k = 0; k < TB_MAX; k++) begin
                if (s == TB_MATCH) begin
                    if (k < best_k) begin
                        best_k    = k;
                        best_lane = lane;
                    end
                    break;
                end
                s = fwd(s, poly_of(lane));
            end
        end
        if (best_k == TB_MAX) begin
            v.exp_nm = 1'b1; v.exp_poly = 2'd0; v.exp_off = 17'(TB_MAX); v.exp_lat = 2 + TB_MAX;
        end else begin
            v.exp_nm = 1'b0; v.exp_poly = 2'(best_lane); v.exp_off = 17'(best_k); v.exp_lat = 3 + best_k;
        end
        return v;
    endfunction

    // Entered at cycle C+2 with the decoder already released
    task automatic collect(input vec_t v, input int stall, input int ready_delay);
        int lat;
        lat = 2;
        if (stall > 0) begin
            enabled = 1'b0;
            repeat (stall) begin
                @(posedge clk_96MHz); #1;
                check("stall_ack", 64'(decoder_ack), 64'd0);
            end
            enabled = 1'b1;
            lat += stall;
        end
        while (res_if.result_valid !== 1'b1 && lat < 100) begin
            @(posedge clk_96MHz); #1;
            lat++;
        end
        check("latency",  64'(lat), 64'(v.exp_lat + stall));
        check("no_match", 64'(res_if.result_no_match), 64'(v.exp_nm));
        check("poly",     64'(res_if.result_poly), 64'(v.exp_poly));
        check("offset",   64'(res_if.result_offset), 64'(v.exp_off));
        check("ts",       64'(res_if.result_ts), 64'(v.ts));
`ifdef LFSR_OFFSET_FINDER_OVERRUN_EN
        check("overrun_clear", 64'(res_if.result_overrun), 64'd0);
`endif
        repeat (ready_delay) begin @(posedge clk_96MHz); #1; end
        if (ready_delay > 0)
            check("hold", {res_if.result_valid, res_if.result_offset, res_if.result_ts},
                          {1'b1, v.exp_off, v.ts});
        res_if.result_ready = 1'b1;
        @(posedge clk_96MHz); #1;
        res_if.result_ready = 1'b0;
        check("accept", {62'd0, res_if.result_valid, busy}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int stall, input int ready_delay);
        decoded_data   = v.word;
        ts_last_data   = v.ts;
        data_availible = 1'b1;
        @(posedge clk_96MHz); #1;
        check("ack_c1", {62'd0, decoder_ack, busy}, 64'd3);
        @(posedge clk_96MHz); #1;
        check("ack_c2", 64'(decoder_ack), 64'd0);
        data_availible = 1'b0;
        collect(v, stall, ready_delay);
    endtask

    initial begin
        vec_t        vecs[$];
        vec_t        v;
        vec_t        v_imm;
        vec_t        v_to;
        logic [16:0] w;
        logic [16:0] w5;
        int          tries;

        res_if.result_ready = 1'b0;

        // Word reaching the terminal state in lane 1 after exactly five steps
        w5 = TB_MATCH;
        for (int i = 0; i < 5; i++) w5 = back(w5, poly_of(1));

        // A word the model says never reaches the terminal state in range
        tries = 0;
        do begin
            w    = 17'($urandom);
            v_to = model(w, 24'h0BEEF0);
            tries++;
        end while ((w == '0 || !v_to.exp_nm) && tries < 1000);

        v_imm = '{word: 17'h00001, ts: 24'h123456, exp_nm: 1'b0, exp_poly: 2'd0, exp_off: 17'd0, exp_lat: 3};
        vecs.push_back(v_imm);
        vecs.push_back('{word: 17'h00000, ts: 24'h00A0A0, exp_nm: 1'b1, exp_poly: 2'd0, exp_off: 17'd0, exp_lat: 2});
        vecs.push_back('{word: w5, ts: 24'h555555, exp_nm: 1'b0, exp_poly: 2'd1, exp_off: 17'd5, exp_lat: 8});
        vecs.push_back('{word: v_to.word, ts: 24'h0BEEF0, exp_nm: 1'b1, exp_poly: 2'd0, exp_off: 17'd16, exp_lat: 18});
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 1) begin
                w = TB_MATCH;
                for (int k = 0; k < int'($urandom_range(0, 15)); k++) w = back(w, poly_of(int'($urandom_range(0, 3))));
            end else begin
                w = 17'($urandom);
            end
            vecs.push_back(model(w, 24'($urandom)));
        end

        // Reset state
        repeat (3) begin @(posedge clk_96MHz); #1; end
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_ack",   64'(decoder_ack), 64'd0);
        check("rst_valid", 64'(res_if.result_valid), 64'd0);
        check("rst_fields", {res_if.result_poly, res_if.result_offset, res_if.result_no_match, res_if.result_ts}, 64'd0);
        reset = 1'b0;
        @(posedge clk_96MHz); #1;

        // Table of vectors
        foreach (vecs[i]) run_vec(vecs[i], 0, (i % 3));

        // Freeze for three cycles mid-search stretches the latency by three
        run_vec(vecs[2], 3, 0);

        // Reset asserted for three cycles in SEARCH
        decoded_data   = v_to.word;
        ts_last_data   = 24'h0BEEF0;
        data_availible = 1'b1;
        @(posedge clk_96MHz); #1;
        @(posedge clk_96MHz); #1;
        data_availible = 1'b0;
        repeat (4) begin @(posedge clk_96MHz); #1; end
        check("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        repeat (3) begin @(posedge clk_96MHz); #1; end
        check("mid_reset", {res_if.result_valid, busy, decoder_ack, res_if.result_no_match,
                            res_if.result_poly, res_if.result_offset, res_if.result_ts}, 64'd0);
        reset = 1'b0;
        @(posedge clk_96MHz); #1;
        run_vec(v_imm, 0, 0);

        // Backpressure with a newer decoder word waiting
        decoded_data   = 17'h00001;
        ts_last_data   = 24'h111111;
        data_availible = 1'b1;
        @(posedge clk_96MHz); #1;
        check("bp_ack1", 64'(decoder_ack), 64'd1);
        @(posedge clk_96MHz); #1;
        data_availible = 1'b0;
        @(posedge clk_96MHz); #1;
        check("bp_valid", 64'(res_if.result_valid), 64'd1);
        decoded_data   = w5;
        ts_last_data   = 24'hABCDEF;
        data_availible = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_96MHz); #1;
            check("bp_no_ack", 64'(decoder_ack), 64'd0);
            check("bp_hold", {res_if.result_valid, res_if.result_no_match, res_if.result_poly,
                              res_if.result_offset, res_if.result_ts},
                             {1'b1, 1'b0, 2'd0, 17'd0, 24'h111111});
        end
`ifdef LFSR_OFFSET_FINDER_OVERRUN_EN
        check("bp_overrun", 64'(res_if.result_overrun), 64'd1);
`endif
        res_if.result_ready = 1'b1;
        @(posedge clk_96MHz); #1;
        res_if.result_ready = 1'b0;
        check("bp_release", {61'd0, res_if.result_valid, busy, decoder_ack}, 64'd0);
        @(posedge clk_96MHz); #1;
        check("bp_ack2", 64'(decoder_ack), 64'd1);
        @(posedge clk_96MHz); #1;
        data_availible = 1'b0;
        v = '{word: w5, ts: 24'hABCDEF, exp_nm: 1'b0, exp_poly: 2'd1, exp_off: 17'd5, exp_lat: 8};
        collect(v, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
